// File: rtl/axis_insert_header_pkg.sv
// Shared types and helpers for the AXI-Stream header inserter.
// Byte ordering throughout: byte 0 lives in [31:24] and is sent first.
package axis_insert_header_pkg;

   localparam int unsigned BYTES = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      FLUSH = 2'd2
   } state_e;

   // Number of set bits in a contiguous keep (works for left- or right-aligned).
   function automatic logic [2:0] keep_to_count(input logic [BYTES-1:0] keep);
      logic [2:0] n;
      n = '0;
      for (int unsigned i = 0; i < BYTES; i++) begin
         n = n + {2'b00, keep[i]};
      end
      return n;
   endfunction

   // Left-aligned keep for a byte count of 0..4.
   function automatic logic [BYTES-1:0] count_to_left_keep(input logic [2:0] cnt);
      logic [BYTES-1:0] k;
      case (cnt)
         3'd0:    k = 4'b0000;
         3'd1:    k = 4'b1000;
         3'd2:    k = 4'b1100;
         3'd3:    k = 4'b1110;
         default: k = 4'b1111;
      endcase
      return k;
   endfunction

   // Expand a per-byte keep into a per-bit data mask.
   function automatic logic [8*BYTES-1:0] keep_to_mask(input logic [BYTES-1:0] keep);
      logic [8*BYTES-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < BYTES; i++) begin
         m[8*i +: 8] = {8{keep[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/axis_insert_header_byte_packer.sv
// Combinational byte packer: appends the valid bytes of an input beat
// behind a left-aligned residual and splits the result into one output
// beat (first 4 bytes) and a new left-aligned residual.
module axis_byte_packer
   import axis_insert_header_pkg::*;
(
   input  logic [31:0] res,
   input  logic [2:0]  res_cnt,
   input  logic [31:0] data_in,
   input  logic [3:0]  keep_in,
   output logic [31:0] out_data,
   output logic [3:0]  out_keep,
   output logic [2:0]  out_cnt,
   output logic [31:0] rest_data,
   output logic [2:0]  rest_cnt,
   output logic [3:0]  total_cnt
);

   logic [31:0] masked_in;
   logic [63:0] joined;
   logic [5:0]  shamt;
   logic [2:0]  in_cnt;
   logic [3:0]  rest_wide;

   // Concatenate residual and masked input, then split into beat + remainder.
   always_comb begin
      in_cnt    = keep_to_count(keep_in);
      masked_in = data_in & keep_to_mask(keep_in);
      shamt     = {res_cnt, 3'b000};
      joined    = {res, 32'h0} | ({masked_in, 32'h0} >> shamt);
      total_cnt = {1'b0, res_cnt} + {1'b0, in_cnt};
      rest_wide = total_cnt - 4'd4;
      if (total_cnt > 4'd4) begin
         out_cnt  = 3'd4;
         rest_cnt = rest_wide[2:0];
      end else begin
         out_cnt  = total_cnt[2:0];
         rest_cnt = 3'd0;
      end
      out_keep  = count_to_left_keep(out_cnt);
      out_data  = joined[63:32] & keep_to_mask(out_keep);
      rest_data = joined[31:0];
   end

endmodule

// File: rtl/axis_insert_header.sv
// AXI-Stream header inserter: prepends 1-4 header bytes to the next packet,
// producing a byte-packed MSB-first 32-bit stream through one register stage.
// Optional simulation checks: define AXIS_INSERT_HEADER_ASSERT_EN.
module axis_insert_header
   import axis_insert_header_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        valid_in,
   output logic        ready_in,
   input  logic [31:0] data_in,
   input  logic [3:0]  keep_in,
   input  logic        last_in,
   input  logic        valid_insert,
   output logic        ready_insert,
   input  logic [31:0] data_insert,
   input  logic [3:0]  keep_insert,
   input  logic [1:0]  byte_insert_cnt,
   output logic        valid_out,
   input  logic        ready_out,
   output logic [31:0] data_out,
   output logic [3:0]  keep_out,
   output logic        last_out
);

   state_e      state_q, state_d;
   logic [31:0] data_out_q, data_out_d;
   logic [3:0]  keep_out_q, keep_out_d;
   logic        last_out_q, last_out_d;
   logic        valid_out_q, valid_out_d;
   logic [31:0] res_q, res_d;
   logic [2:0]  resn_q, resn_d;

   logic        can_load;
   logic        in_fire;
   logic        ins_fire;
   logic [2:0]  hdr_cnt;
   logic [5:0]  hdr_shift;

   logic [31:0] pk_out_data;
   logic [3:0]  pk_out_keep;
   logic [2:0]  pk_out_cnt;
   logic [31:0] pk_rest_data;
   logic [2:0]  pk_rest_cnt;
   logic [3:0]  pk_total;

   axis_byte_packer u_packer (
      .res       (res_q),
      .res_cnt   (resn_q),
      .data_in   (data_in),
      .keep_in   (keep_in),
      .out_data  (pk_out_data),
      .out_keep  (pk_out_keep),
      .out_cnt   (pk_out_cnt),
      .rest_data (pk_rest_data),
      .rest_cnt  (pk_rest_cnt),
      .total_cnt (pk_total)
   );

   assign can_load  = !valid_out_q || ready_out;
   assign in_fire   = valid_in && ready_in;
   assign ins_fire  = valid_insert && ready_insert;
   // byte_insert_cnt and keep_insert agree for legal headers; the count sets
   // the alignment shift, keep masks off any stray upper bytes.
   assign hdr_cnt   = {1'b0, byte_insert_cnt} + 3'd1;
   assign hdr_shift = {3'd4 - hdr_cnt, 3'b000};

   assign valid_out = valid_out_q;
   assign data_out  = data_out_q;
   assign keep_out  = keep_out_q;
   assign last_out  = last_out_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rstn) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic. The packet's final beat may still sit in the output
   // register when IDLE is entered; ready_in stays gated by that register.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (ins_fire) state_d = DATA;
         DATA:  if (in_fire && last_in) state_d = (pk_total > 4'd4) ? FLUSH : IDLE;
         FLUSH: if (can_load) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs.
   always_comb begin
      ready_insert = (state_q == IDLE) && !rstn;
      ready_in     = (state_q == DATA) && can_load && !rstn;
   end

   // Datapath next values: output beat register and residual bytes.
   always_comb begin
      data_out_d  = data_out_q;
      keep_out_d  = keep_out_q;
      last_out_d  = last_out_q;
      valid_out_d = valid_out_q && !ready_out;
      res_d       = res_q;
      resn_d      = resn_q;
      unique case (state_q)
         IDLE: begin
            if (ins_fire) begin
               res_d  = (data_insert & keep_to_mask(keep_insert)) << hdr_shift;
               resn_d = hdr_cnt;
            end
         end
         DATA: begin
            if (in_fire) begin
               data_out_d  = pk_out_data;
               keep_out_d  = pk_out_keep;
               last_out_d  = last_in && (pk_total <= 4'd4);
               valid_out_d = 1'b1;
               res_d       = pk_rest_data;
               resn_d      = pk_rest_cnt;
            end
         end
         FLUSH: begin
            if (can_load) begin
               data_out_d  = res_q & keep_to_mask(count_to_left_keep(resn_q));
               keep_out_d  = count_to_left_keep(resn_q);
               last_out_d  = 1'b1;
               valid_out_d = 1'b1;
               res_d       = '0;
               resn_d      = '0;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rstn) begin
         data_out_q  <= '0;
         keep_out_q  <= '0;
         last_out_q  <= 1'b0;
         valid_out_q <= 1'b0;
         res_q       <= '0;
         resn_q      <= '0;
      end else begin
         data_out_q  <= data_out_d;
         keep_out_q  <= keep_out_d;
         last_out_q  <= last_out_d;
         valid_out_q <= valid_out_d;
         res_q       <= res_d;
         resn_q      <= resn_d;
      end
   end

`ifdef AXIS_INSERT_HEADER_ASSERT_EN
   a_insert_keep: assert property (@(posedge clk) disable iff (rstn)
      (valid_insert && ready_insert) |->
         ((keep_insert inside {4'b0001, 4'b0011, 4'b0111, 4'b1111}) &&
          (keep_to_count(keep_insert) == hdr_cnt)));

   a_in_keep: assert property (@(posedge clk) disable iff (rstn)
      (valid_in && ready_in) |->
         ((keep_in inside {4'b1000, 4'b1100, 4'b1110, 4'b1111}) &&
          (last_in || keep_in == 4'b1111)));

   a_out_stable: assert property (@(posedge clk) disable iff (rstn)
      (valid_out && !ready_out) |=>
         (valid_out && $stable(data_out) && $stable(keep_out) && $stable(last_out)));
`endif

endmodule

// File: tb/tb_axis_insert_header.sv
// Scoreboard bench for axis_insert_header: stimulus pushes expected output
// beats, a negedge monitor pops and compares every accepted output beat.
module tb_axis_insert_header;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } beat_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        valid_in = 1'b0;
   logic        ready_in;
   logic [31:0] data_in = '0;
   logic [3:0]  keep_in = '0;
   logic        last_in = 1'b0;
   logic        valid_insert = 1'b0;
   logic        ready_insert;
   logic [31:0] data_insert = '0;
   logic [3:0]  keep_insert = '0;
   logic [1:0]  byte_insert_cnt = '0;
   logic        valid_out;
   logic        ready_out = 1'b1;
   logic [31:0] data_out;
   logic [3:0]  keep_out;
   logic        last_out;

   int    n_total = 0;
   int    n_pass  = 0;
   int    cyc = 0;
   int    stall_until = 0;
   bit    rand_rdy = 1'b0;
   beat_t exp_q[$];
   beat_t got_q[$];
   logic [31:0] pay_q[$];

   axis_insert_header dut (
      .clk             (clk),
      .rstn            (rstn),
      .valid_in        (valid_in),
      .ready_in        (ready_in),
      .data_in         (data_in),
      .keep_in         (keep_in),
      .last_in         (last_in),
      .valid_insert    (valid_insert),
      .ready_insert    (ready_insert),
      .data_insert     (data_insert),
      .keep_insert     (keep_insert),
      .byte_insert_cnt (byte_insert_cnt),
      .valid_out       (valid_out),
      .ready_out       (ready_out),
      .data_out        (data_out),
      .keep_out        (keep_out),
      .last_out        (last_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Sink ready: forced low during a stall window, else random or always high.
   always @(posedge clk) begin
      #2;
      if (cyc < stall_until) ready_out = 1'b0;
      else if (rand_rdy)     ready_out = 1'($urandom_range(0, 1));
      else                   ready_out = 1'b1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
   endtask

   task automatic timeout_fail(input string name);
      n_total++;
      $display("FAIL %s: handshake timed out (t=%0t)", name, $time);
   endtask

   // Monitor: every accepted beat must match the head of the scoreboard;
   // a stalled beat must not change until accepted.
   logic  held_v = 1'b0;
   beat_t held;
   always @(negedge clk) begin
      beat_t e;
      if (rstn) begin
         held_v = 1'b0;
      end else begin
         if (held_v) begin
            chk("stall_valid", {63'd0, valid_out}, 64'd1);
            chk("stall_hold", {27'd0, data_out, keep_out, last_out},
                {27'd0, held.d, held.k, held.l});
         end
         if (valid_out && ready_out) begin
            got_q.push_back('{data_out, keep_out, last_out});
            if (exp_q.size() == 0) begin
               timeout_fail("unexpected_beat");
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", {32'd0, data_out}, {32'd0, e.d});
               chk("beat_keep", {60'd0, keep_out}, {60'd0, e.k});
               chk("beat_last", {63'd0, last_out}, {63'd0, e.l});
            end
         end
         held_v = valid_out && !ready_out;
         held   = '{data_out, keep_out, last_out};
      end
   end

   // Reference model: header bytes then payload bytes, chopped into 4-byte beats.
   task automatic push_expected(input logic [31:0] hdr, input logic [3:0] hkeep,
                                input logic [3:0] lastkeep);
      logic [7:0]  b[$];
      logic [3:0]  k;
      beat_t       bt;
      for (int i = 3; i >= 0; i--) if (hkeep[i]) b.push_back(hdr[8*i +: 8]);
      for (int w = 0; w < pay_q.size(); w++) begin
         k = (w == pay_q.size() - 1) ? lastkeep : 4'b1111;
         for (int i = 3; i >= 0; i--) if (k[i]) b.push_back(pay_q[w][8*i +: 8]);
      end
      while (b.size() != 0) begin
         bt.d = '0;
         bt.k = '0;
         for (int j = 0; j < 4; j++) begin
            if (b.size() != 0) begin
               bt.d[31-8*j -: 8] = b.pop_front();
               bt.k[3-j] = 1'b1;
            end
         end
         bt.l = (b.size() == 0);
         exp_q.push_back(bt);
      end
   endtask

   task automatic send_hdr(input logic [31:0] d, input logic [3:0] k,
                           input logic [1:0] c, input bit hold);
      int n = 0;
      bit done = 1'b0;
      valid_insert = 1'b1;
      data_insert = d;
      keep_insert = k;
      byte_insert_cnt = c;
      while (!done && n < 500) begin
         @(negedge clk);
         if (ready_insert) done = 1'b1;
         else n++;
      end
      if (!done) timeout_fail("hdr_timeout");
      @(posedge clk);
      #1;
      if (!hold) valid_insert = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [3:0] k,
                            input logic l, input int gap);
      int n = 0;
      bit done = 1'b0;
      if (gap > 0) begin
         repeat (gap) @(posedge clk);
         #1;
      end
      valid_in = 1'b1;
      data_in = d;
      keep_in = k;
      last_in = l;
      while (!done && n < 500) begin
         @(negedge clk);
         if (ready_in) done = 1'b1;
         else n++;
      end
      if (!done) timeout_fail("beat_timeout");
      @(posedge clk);
      #1;
      valid_in = 1'b0;
   endtask

   task automatic send_payload(input logic [3:0] lastkeep, input bit rgap);
      for (int w = 0; w < pay_q.size(); w++) begin
         send_beat(pay_q[w], (w == pay_q.size() - 1) ? lastkeep : 4'b1111,
                   (w == pay_q.size() - 1), rgap ? int'($urandom_range(0, 2)) : 0);
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      repeat (2) @(posedge clk);
      #1;
      chk(name, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic load_d_words();
      pay_q.delete();
      for (int i = 0; i < 6; i++) pay_q.push_back(32'h1020_3040 + 32'h0101_0101 * i);
   endtask

   initial begin
      logic [3:0] lk_tab[4];
      lk_tab[0] = 4'b1111; lk_tab[1] = 4'b1110; lk_tab[2] = 4'b1100; lk_tab[3] = 4'b1000;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid_out", {63'd0, valid_out}, 64'd0);
      chk("rst_data_out", {32'd0, data_out}, 64'd0);
      chk("rst_keep_out", {60'd0, keep_out}, 64'd0);
      chk("rst_last_out", {63'd0, last_out}, 64'd0);
      chk("rst_ready_insert", {63'd0, ready_insert}, 64'd0);
      chk("rst_ready_in", {63'd0, ready_in}, 64'd0);
      @(posedge clk);
      #1;
      rstn = 1'b0;
      @(negedge clk);
      chk("idle_ready_insert", {63'd0, ready_insert}, 64'd1);
      chk("idle_ready_in", {63'd0, ready_in}, 64'd0);
      @(posedge clk);
      #1;

      // Test 1: 3-byte header, 6 beats, last keep 1100
      load_d_words();
      got_q.delete();
      push_expected(32'hABCD_EF88, 4'b0111, 4'b1100);
      send_hdr(32'hABCD_EF88, 4'b0111, 2'd2, 1'b0);
      send_payload(4'b1100, 1'b0);
      drain("t1_drain");
      chk("t1_beats", 64'(got_q.size()), 64'd7);
      if (got_q.size() == 7) begin
         chk("t1_beat0", {32'd0, got_q[0].d}, {32'd0, 32'hCDEF_8810});
         chk("t1_beat6", {27'd0, got_q[6].d, got_q[6].k, got_q[6].l},
             {27'd0, 32'h2500_0000, 4'b1000, 1'b1});
      end

      // Test 2: same packet, sink stalls 5 cycles around the last input beat
      got_q.delete();
      push_expected(32'hABCD_EF88, 4'b0111, 4'b1100);
      send_hdr(32'hABCD_EF88, 4'b0111, 2'd2, 1'b0);
      for (int w = 0; w < 5; w++) send_beat(pay_q[w], 4'b1111, 1'b0, 0);
      stall_until = cyc + 5;
      @(negedge clk);
      chk("t2_stall_ready_in", {63'd0, ready_in}, 64'd0);
      send_beat(pay_q[5], 4'b1100, 1'b1, 0);
      drain("t2_drain");
      chk("t2_beats", 64'(got_q.size()), 64'd7);

      // Test 3: two back-to-back packets, valid_insert held high
      push_expected(32'hABCD_EF88, 4'b0111, 4'b1100);
      push_expected(32'hABCD_EF88, 4'b0111, 4'b1100);
      fork
         begin
            send_hdr(32'hABCD_EF88, 4'b0111, 2'd2, 1'b1);
            send_hdr(32'hABCD_EF88, 4'b0111, 2'd2, 1'b0);
         end
         begin
            send_payload(4'b1100, 1'b0);
            send_payload(4'b1100, 1'b0);
         end
      join
      drain("t3_drain");

      // Test 4: full-word header, one full payload beat
      exp_q.push_back('{32'h1122_3344, 4'b1111, 1'b0});
      exp_q.push_back('{32'hA1A2_A3A4, 4'b1111, 1'b1});
      send_hdr(32'h1122_3344, 4'b1111, 2'd3, 1'b0);
      send_beat(32'hA1A2_A3A4, 4'b1111, 1'b1, 0);
      drain("t4_drain");

      // Test 5: 1-byte header (stray upper bytes), 3-byte payload -> one beat
      exp_q.push_back('{32'hAAB1_B2B3, 4'b1111, 1'b1});
      send_hdr(32'h5566_77AA, 4'b0001, 2'd0, 1'b0);
      send_beat(32'hB1B2_B3FF, 4'b1110, 1'b1, 0);
      drain("t5_drain");

      // Test 6: random valid_in gaps and ready_out over 10 transfers
      rand_rdy = 1'b1;
      pay_q.delete();
      for (int i = 0; i < 10; i++) pay_q.push_back($urandom);
      begin
         logic [3:0] lk;
         lk = lk_tab[$urandom_range(0, 3)];
         push_expected(32'h0000_9ABC, 4'b0011, lk);
         send_hdr(32'h0000_9ABC, 4'b0011, 2'd1, 1'b0);
         send_payload(lk, 1'b1);
      end
      drain("t6_drain");
      rand_rdy = 1'b0;

      // Test 7: reset mid-packet discards pending output
      stall_until = cyc + 1000;
      send_hdr(32'h0000_00EE, 4'b0001, 2'd0, 1'b0);
      send_beat(32'h1234_5678, 4'b1111, 1'b0, 0);
      @(negedge clk);
      chk("t7_pending", {63'd0, valid_out}, 64'd1);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t7_rst_out", {27'd0, valid_out, data_out, keep_out, last_out}, 64'd0);
      chk("t7_rst_ready_insert", {63'd0, ready_insert}, 64'd0);
      @(posedge clk);
      #1;
      rstn = 1'b0;
      stall_until = 0;
      @(negedge clk);
      chk("t7_idle_ready_insert", {63'd0, ready_insert}, 64'd1);
      chk("t7_idle_ready_in", {63'd0, ready_in}, 64'd0);
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_total);
      $fatal(1);
   end

endmodule
